// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Scans a ROWS x COLS matrix keypad by driving one column low at a time and
// sensing the active-low row lines. It debounces whole scan frames and reports
// single-cycle press, repeat and release events to the downstream datapath.
// Frames where more than one key is closed are rejected and flagged.
//
// Handshake: there is no back-pressure. key_valid, key_release and multi_key
// are single-cycle pulses that the consumer must sample on the cycle they are
// high. key_code is qualified by key_valid and holds until the next event.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   row         in   [ROWS]   row sense, 0 = key closed on the driven column
//   col         out  [COLS]   column drive, exactly one bit low
//   key_code    out  [CODE_W] row_idx*COLS + col_idx of the reported key
//   key_valid   out  pulse: initial press or repeat event
//   key_repeat  out  qualifies key_valid (1 = repeat, 0 = initial press)
//   key_release out  pulse: held key accepted as released
//   key_held    out  level: a key is in the pressed state
//   multi_key   out  pulse: the last frame saw more than one closed key
//   dbg_state   out  [2]      current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 30,
   parameter int REPEAT_RATE     = 6,
   localparam int CODE_W         = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   row,
   output logic [COLS-1:0]   col,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_repeat,
   output logic              key_release,
   output logic              key_held,
   output logic              multi_key,
   output logic [1:0]        dbg_state
);

   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W   = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2
   } state_t;

   // scan timing
   logic [COL_W-1:0]   col_idx_q, col_idx_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               last_dwell;
   logic               frame_end;

   // per-frame accumulation: closed-key count saturates at 2 (= multi)
   logic [1:0]         hit_cnt_q, hit_cnt_d;
   logic [CODE_W-1:0]  hit_code_q, hit_code_d;
   logic [1:0]         samp_cnt;
   logic [CODE_W-1:0]  samp_code;
   logic [2:0]         sum_cnt;
   logic [1:0]         tot_cnt;
   logic [CODE_W-1:0]  tot_code;
   logic               frame_single;
   logic               frame_multi;

   // key FSM
   state_t             state_q, state_d;
   logic [CODE_W-1:0]  cand_q, cand_d;
   logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
   logic [DEB_W-1:0]   rel_cnt_q, rel_cnt_d;
   logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic               rep_first_q, rep_first_d;

   // registered outputs
   logic [CODE_W-1:0]  key_code_q, key_code_d;
   logic               key_valid_q, key_valid_d;
   logic               key_repeat_q, key_repeat_d;
   logic               key_release_q, key_release_d;
   logic               multi_key_q, multi_key_d;

   // ---------------------------------------------------------------------------
   // Column scan: dwell SCAN_DIV cycles per column, row sampled on the last one.
   // row is used directly; the debounce tolerates the odd bad sample, but the
   // pins should still be synchronised before reaching this block.
   // ---------------------------------------------------------------------------
   always_comb begin
      last_dwell = (dwell_q == DWELL_W'(SCAN_DIV - 1));
      frame_end  = last_dwell && (col_idx_q == COL_W'(COLS - 1));
      dwell_d    = last_dwell ? '0 : dwell_q + 1'b1;
      col_idx_d  = col_idx_q;
      if (last_dwell) begin
         col_idx_d = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
      end
   end

   assign col = ~(COLS'(1) << col_idx_q);

   // ---------------------------------------------------------------------------
   // Frame classification. tot_* merges this column's sample with the rest of
   // the frame so the result is available on the frame-end cycle itself.
   // ---------------------------------------------------------------------------
   always_comb begin
      samp_cnt  = 2'd0;
      samp_code = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (!row[r]) begin
            if (samp_cnt != 2'd2) samp_cnt = samp_cnt + 2'd1;
            samp_code = CODE_W'(r * COLS + int'(col_idx_q));
         end
      end
      sum_cnt  = {1'b0, hit_cnt_q} + {1'b0, samp_cnt};
      tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
      tot_code = (samp_cnt != 2'd0) ? samp_code : hit_code_q;

      hit_cnt_d  = hit_cnt_q;
      hit_code_d = hit_code_q;
      if (frame_end) begin
         hit_cnt_d  = 2'd0;
         hit_code_d = '0;
      end else if (last_dwell) begin
         hit_cnt_d  = tot_cnt;
         hit_code_d = tot_code;
      end

      frame_single = frame_end && (tot_cnt == 2'd1);
      frame_multi  = frame_end && (tot_cnt == 2'd2);
   end

   // ---------------------------------------------------------------------------
   // Key FSM, advanced once per frame. cand_q is the debounce candidate and,
   // once pressed, the held key.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cand_d        = cand_q;
      deb_cnt_d     = deb_cnt_q;
      rel_cnt_d     = rel_cnt_q;
      rep_cnt_d     = rep_cnt_q;
      rep_first_d   = rep_first_q;
      key_code_d    = key_code_q;
      key_valid_d   = 1'b0;
      key_repeat_d  = 1'b0;
      key_release_d = 1'b0;
      multi_key_d   = frame_multi;

      if (frame_end) begin
         case (state_q)
            ST_IDLE: begin
               if (frame_single) begin
                  cand_d = tot_code;
                  if (DEBOUNCE_FRAMES <= 1) begin
                     state_d     = ST_PRESSED;
                     key_valid_d = 1'b1;
                     key_code_d  = tot_code;
                     rel_cnt_d   = '0;
                     rep_cnt_d   = '0;
                     rep_first_d = 1'b1;
                  end else begin
                     state_d   = ST_DEBOUNCE;
                     deb_cnt_d = DEB_W'(1);
                  end
               end
            end

            ST_DEBOUNCE: begin
               if (frame_single && (tot_code == cand_q)) begin
                  if (int'(deb_cnt_q) + 1 >= DEBOUNCE_FRAMES) begin
                     state_d     = ST_PRESSED;
                     deb_cnt_d   = '0;
                     key_valid_d = 1'b1;
                     key_code_d  = cand_q;
                     rel_cnt_d   = '0;
                     rep_cnt_d   = '0;
                     rep_first_d = 1'b1;
                  end else begin
                     deb_cnt_d = deb_cnt_q + 1'b1;
                  end
               end else if (frame_single) begin
                  cand_d    = tot_code;
                  deb_cnt_d = DEB_W'(1);
               end else begin
                  state_d   = ST_IDLE;
                  deb_cnt_d = '0;
               end
            end

            ST_PRESSED: begin
               if (frame_single && (tot_code == cand_q)) begin
                  rel_cnt_d = '0;
                  if (REPEAT_EN != 0) begin
                     // First repeat waits REPEAT_DELAY held frames, later
                     // ones REPEAT_RATE; the count restarts on every event.
                     if (int'(rep_cnt_q) + 1 >=
                         (rep_first_q ? REPEAT_DELAY : REPEAT_RATE)) begin
                        key_valid_d  = 1'b1;
                        key_repeat_d = 1'b1;
                        key_code_d   = cand_q;
                        rep_cnt_d    = '0;
                        rep_first_d  = 1'b0;
                     end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                     end
                  end
               end else begin
                  // A non-matching frame restarts the repeat interval.
                  rep_cnt_d = '0;
                  if (int'(rel_cnt_q) + 1 >= DEBOUNCE_FRAMES) begin
                     state_d       = ST_IDLE;
                     rel_cnt_d     = '0;
                     deb_cnt_d     = '0;
                     key_release_d = 1'b1;
                  end else begin
                     rel_cnt_d = rel_cnt_q + 1'b1;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_idx_q     <= '0;
         dwell_q       <= '0;
         hit_cnt_q     <= 2'd0;
         hit_code_q    <= '0;
         state_q       <= ST_IDLE;
         cand_q        <= '0;
         deb_cnt_q     <= '0;
         rel_cnt_q     <= '0;
         rep_cnt_q     <= '0;
         rep_first_q   <= 1'b0;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         key_repeat_q  <= 1'b0;
         key_release_q <= 1'b0;
         multi_key_q   <= 1'b0;
      end else begin
         col_idx_q     <= col_idx_d;
         dwell_q       <= dwell_d;
         hit_cnt_q     <= hit_cnt_d;
         hit_code_q    <= hit_code_d;
         state_q       <= state_d;
         cand_q        <= cand_d;
         deb_cnt_q     <= deb_cnt_d;
         rel_cnt_q     <= rel_cnt_d;
         rep_cnt_q     <= rep_cnt_d;
         rep_first_q   <= rep_first_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_repeat_q  <= key_repeat_d;
         key_release_q <= key_release_d;
         multi_key_q   <= multi_key_d;
      end
   end

   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_repeat  = key_repeat_q;
   assign key_release = key_release_q;
   assign multi_key   = multi_key_q;
   assign key_held    = (state_q == ST_PRESSED);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// Bench for keypad_matrix_scanner with a 4x4 matrix, 4-cycle dwell (16-cycle
// frames), 3-frame debounce, repeat after 8 then every 2 held frames.
// Two instances run in lockstep: dut0 with repeat enabled, dut1 without.
// Keys are changed only at frame starts, so the reference model works on
// whole frames: the set of closed keys per frame determines the events seen
// on the first cycle of the following frame.
// -----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int SDIV = 4;
   localparam int DEB  = 3;
   localparam int RDLY = 8;
   localparam int RRAT = 2;
   localparam int FRAME = COLS * SDIV;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // keypad model: row[r] follows col[c] for every closed key (r, c)
   logic [15:0] keys_mask = '0;
   logic [3:0]  row;
   logic [3:0]  col0, col1;
   logic [3:0]  key_code0, key_code1;
   logic        key_valid0, key_repeat0, key_release0, key_held0, multi_key0;
   logic        key_valid1, key_repeat1, key_release1, key_held1, multi_key1;
   logic [1:0]  dbg_state0, dbg_state1;

   always_comb begin
      row = '1;
      for (int k = 0; k < 16; k++) begin
         if (keys_mask[k] && !col0[k % COLS]) row[k / COLS] = 1'b0;
      end
   end

   keypad_matrix_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_FRAMES(DEB),
      .REPEAT_EN(1), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRAT)
   ) dut0 (
      .clk(clk), .rst(rst), .row(row), .col(col0), .key_code(key_code0),
      .key_valid(key_valid0), .key_repeat(key_repeat0),
      .key_release(key_release0), .key_held(key_held0),
      .multi_key(multi_key0), .dbg_state(dbg_state0)
   );

   keypad_matrix_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_FRAMES(DEB),
      .REPEAT_EN(0), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRAT)
   ) dut1 (
      .clk(clk), .rst(rst), .row(row), .col(col1), .key_code(key_code1),
      .key_valid(key_valid1), .key_repeat(key_repeat1),
      .key_release(key_release1), .key_held(key_held1),
      .multi_key(multi_key1), .dbg_state(dbg_state1)
   );

   int checks = 0;
   int errors = 0;

   // event tallies per test
   int n0_valid, n0_rep, n0_rel, n0_multi;
   int n1_valid, n1_rep, n1_rel;

   // ---------------------------------------------------------------------------
   // Frame-level reference model (repeat enabled)
   // ---------------------------------------------------------------------------
   bit m_pressed;
   int m_cand, m_run, m_code, m_rel, m_since;
   bit m_first;
   bit e_valid, e_repeat, e_release, e_multi, e_held;
   int e_code;

   task automatic model_reset();
      m_pressed = 0; m_cand = 0; m_run = 0; m_code = 0; m_rel = 0;
      m_since = 0; m_first = 0;
      e_valid = 0; e_repeat = 0; e_release = 0; e_multi = 0; e_held = 0;
      e_code = 0;
   endtask

   task automatic model_frame(input logic [15:0] m);
      int n, code, target;
      n = $countones(m);
      code = 0;
      for (int k = 15; k >= 0; k--) if (m[k]) code = k;
      e_valid = 0; e_repeat = 0; e_release = 0;
      e_multi = (n > 1);
      if (!m_pressed) begin
         if (n == 1 && code == m_cand && m_run > 0) m_run++;
         else if (n == 1) begin m_cand = code; m_run = 1; end
         else m_run = 0;
         if (m_run >= DEB) begin
            e_valid = 1; e_code = m_cand; m_code = m_cand;
            m_pressed = 1; m_since = 0; m_first = 1; m_rel = 0; m_run = 0;
         end
      end else begin
         if (n == 1 && code == m_code) begin
            m_rel = 0;
            m_since++;
            target = m_first ? RDLY : RRAT;
            if (m_since == target) begin
               e_valid = 1; e_repeat = 1; e_code = m_code;
               m_since = 0; m_first = 0;
            end
         end else begin
            m_since = 0;
            m_rel++;
            if (m_rel == DEB) begin
               e_release = 1; m_pressed = 0; m_run = 0; m_rel = 0;
            end
         end
      end
      e_held = m_pressed;
   endtask

   task automatic clear_tallies();
      n0_valid = 0; n0_rep = 0; n0_rel = 0; n0_multi = 0;
      n1_valid = 0; n1_rep = 0; n1_rel = 0;
   endtask

   // ---------------------------------------------------------------------------
   // Driver: apply mask for one frame starting at a negedge on frame cycle 0,
   // checking every cycle against the model; ends on the next frame's cycle 0.
   // ---------------------------------------------------------------------------
   task automatic run_frame(input logic [15:0] m);
      logic [3:0] exp_col;
      bit pv, pr, prel, pm;
      for (int i = 0; i < FRAME; i++) begin
         if (i == 0) keys_mask = m;
         #1;
         exp_col = 4'b1111 ^ (4'b0001 << (i / SDIV));
         pv   = (i == 0) ? e_valid   : 1'b0;
         pr   = (i == 0) ? e_repeat  : 1'b0;
         prel = (i == 0) ? e_release : 1'b0;
         pm   = (i == 0) ? e_multi   : 1'b0;
         checks++;
         if (col0 !== exp_col || col1 !== exp_col) begin
            errors++;
            $display("FAIL col cyc%0d: got %b/%b expected %b", i, col0, col1, exp_col);
         end
         checks++;
         if (key_valid0 !== pv || key_repeat0 !== pr) begin
            errors++;
            $display("FAIL key_valid/repeat cyc%0d: got %b/%b expected %b/%b",
                     i, key_valid0, key_repeat0, pv, pr);
         end
         checks++;
         if (key_release0 !== prel || key_release1 !== prel) begin
            errors++;
            $display("FAIL key_release cyc%0d: got %b/%b expected %b",
                     i, key_release0, key_release1, prel);
         end
         checks++;
         if (multi_key0 !== pm || multi_key1 !== pm) begin
            errors++;
            $display("FAIL multi_key cyc%0d: got %b/%b expected %b", i, multi_key0, multi_key1, pm);
         end
         checks++;
         if (key_held0 !== e_held || key_held1 !== e_held) begin
            errors++;
            $display("FAIL key_held cyc%0d: got %b/%b expected %b", i, key_held0, key_held1, e_held);
         end
         checks++;
         if (key_code0 !== 4'(e_code)) begin
            errors++;
            $display("FAIL key_code cyc%0d: got %0d expected %0d", i, key_code0, e_code);
         end
         checks++;
         if (key_repeat1 && !key_valid1) begin
            errors++;
            $display("FAIL dut1 key_repeat without key_valid cyc%0d", i);
         end
         if (key_valid0) n0_valid++;
         if (key_valid0 && key_repeat0) n0_rep++;
         if (key_release0) n0_rel++;
         if (multi_key0) n0_multi++;
         if (key_valid1) n1_valid++;
         if (key_valid1 && key_repeat1) n1_rep++;
         if (key_release1) n1_rel++;
         @(negedge clk);
      end
      model_frame(m);
   endtask

   task automatic run_frames(input logic [15:0] m, input int n);
      for (int f = 0; f < n; f++) run_frame(m);
   endtask

   function automatic logic [15:0] key_bit(input int k);
      logic [15:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      keys_mask = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (col0 !== 4'b1110 || key_code0 !== 4'd0 || key_valid0 !== 1'b0 ||
          key_repeat0 !== 1'b0 || key_release0 !== 1'b0 || key_held0 !== 1'b0 ||
          multi_key0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: col=%b code=%0d v=%b r=%b rel=%b h=%b m=%b expected col=1110 rest 0",
                  col0, key_code0, key_valid0, key_repeat0, key_release0, key_held0, multi_key0);
      end
      clear_tallies();
      run_frames('0, 2);
   endtask

   task automatic test_press_release();
      clear_tallies();
      run_frames(key_bit(5), 5);
      run_frames('0, 4);
      checks++;
      if (n0_valid !== 1 || n0_rep !== 0) begin
         errors++;
         $display("FAIL press_count: got valid=%0d rep=%0d expected 1/0", n0_valid, n0_rep);
      end
      checks++;
      if (n0_rel !== 1) begin
         errors++;
         $display("FAIL release_count: got %0d expected 1", n0_rel);
      end
   endtask

   task automatic test_bounce();
      clear_tallies();
      run_frame(key_bit(10));
      run_frame('0);
      run_frame(key_bit(10));
      run_frames('0, 4);
      checks++;
      if (n0_valid !== 0 || n0_rel !== 0 || n1_valid !== 0) begin
         errors++;
         $display("FAIL bounce: got valid=%0d rel=%0d expected 0/0", n0_valid, n0_rel);
      end
   endtask

   task automatic test_repeat();
      clear_tallies();
      run_frames(key_bit(14), 20);
      run_frames('0, 4);
      // press at end of frame 3, repeats after 8, 10, 12, 14, 16 held frames
      checks++;
      if (n0_valid !== 6 || n0_rep !== 5) begin
         errors++;
         $display("FAIL repeat_count: got valid=%0d rep=%0d expected 6/5", n0_valid, n0_rep);
      end
      checks++;
      if (n1_valid !== 1 || n1_rep !== 0 || n1_rel !== 1) begin
         errors++;
         $display("FAIL no_repeat_dut: got valid=%0d rep=%0d rel=%0d expected 1/0/1",
                  n1_valid, n1_rep, n1_rel);
      end
   endtask

   task automatic test_multi_key();
      clear_tallies();
      run_frames(key_bit(1) | key_bit(5), 4);
      run_frames('0, 2);
      checks++;
      if (n0_multi !== 4 || n0_valid !== 0) begin
         errors++;
         $display("FAIL multi_count: got multi=%0d valid=%0d expected 4/0", n0_multi, n0_valid);
      end
   endtask

   task automatic test_reset_mid_hold();
      run_frames(key_bit(3), 5);
      checks++;
      if (key_held0 !== 1'b1 || key_code0 !== 4'd3) begin
         errors++;
         $display("FAIL held_before_reset: got held=%b code=%0d expected 1/3", key_held0, key_code0);
      end
      for (int i = 0; i < 7; i++) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (col0 !== 4'b1110 || key_held0 !== 1'b0 || key_held1 !== 1'b0 ||
          key_code0 !== 4'd0 || key_valid0 !== 1'b0 || key_release0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_hold: col=%b held=%b code=%0d v=%b rel=%b expected 1110/0/0/0/0",
                  col0, key_held0, key_code0, key_valid0, key_release0);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      clear_tallies();
      run_frames('0, 4);
      checks++;
      if (n0_rel !== 0 || n1_rel !== 0) begin
         errors++;
         $display("FAIL release_after_reset: got %0d/%0d expected 0", n0_rel, n1_rel);
      end
   endtask

   task automatic test_random();
      int frames, sel, len, k1, k2;
      logic [15:0] m;
      frames = 0;
      while (frames < 60) begin
         sel = $urandom_range(0, 9);
         if (sel <= 2) begin
            m = '0;
            len = $urandom_range(1, 4);
         end else if (sel <= 8) begin
            m = key_bit($urandom_range(0, 15));
            len = $urandom_range(1, 14);
         end else begin
            k1 = $urandom_range(0, 15);
            k2 = (k1 + $urandom_range(1, 15)) % 16;
            m = key_bit(k1) | key_bit(k2);
            len = $urandom_range(1, 2);
         end
         run_frames(m, len);
         frames += len;
      end
      run_frames('0, 4);
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_bounce();
      test_repeat();
      test_multi_key();
      test_reset_mid_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
